// File: rtl/disparity_selector_pkg.sv
// disparity_selector_pkg: shared widths, FSM encoding and the second-best sentinel.
package disparity_selector_pkg;
  localparam int NUM_BITS_IN = 14;
  localparam int DISP_BITS = 4;
  localparam logic [63:0] SECOND_INIT = '1;
  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;
endpackage

// File: rtl/disparity_selector_if.sv
// disparity_selector_if: window-sum input stream and per-pixel result bundle.
interface disparity_selector_if
  import disparity_selector_pkg::*;
#(
  parameter int num_bits_in = NUM_BITS_IN,
  parameter int disp_bits   = DISP_BITS
) ();
  logic [num_bits_in-1:0] sum_in;
  logic                   sum_valid;
  logic                   sum_first;
  logic [disp_bits-1:0]   disparity;
  logic [num_bits_in-1:0] min_sum;
  logic                   confident;
  logic                   disp_valid;
  logic                   sweep_err;
  modport master (
    output sum_in, sum_valid, sum_first,
    input  disparity, min_sum, confident, disp_valid, sweep_err
  );
  modport slave (
    input  sum_in, sum_valid, sum_first,
    output disparity, min_sum, confident, disp_valid, sweep_err
  );
endinterface

// File: rtl/disparity_selector_min_pair_tracker.sv
// min_pair_tracker: running best/second-best sum and winning index for one sweep.
module min_pair_tracker
  import disparity_selector_pkg::*;
#(
  parameter int num_bits_in = NUM_BITS_IN,
  parameter int disp_bits   = DISP_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_i,
  input  logic                   upd_i,
  input  logic [num_bits_in-1:0] sum_i,
  input  logic [disp_bits-1:0]   idx_i,
  output logic [num_bits_in-1:0] best_o,
  output logic [num_bits_in-1:0] second_o,
  output logic [disp_bits-1:0]   best_idx_o
);
  localparam logic [num_bits_in-1:0] ONES = SECOND_INIT[num_bits_in-1:0];
  logic [num_bits_in-1:0] best_q, best_d, second_q, second_d;
  logic [disp_bits-1:0]   idx_q, idx_d;
  logic                   lt_best, lt_second;
  assign lt_best   = sum_i < best_q;
  assign lt_second = sum_i < second_q;
  // strict compares: an equal sum never displaces the lower-index winner
  assign best_d   = (load_i || (upd_i && lt_best)) ? sum_i : best_q;
  assign idx_d    = load_i ? '0 : (upd_i && lt_best) ? idx_i : idx_q;
  assign second_d = load_i ? ONES : !upd_i ? second_q : lt_best ? best_q :
                    lt_second ? sum_i : second_q;
  // outputs show the state including the current beat so the last beat can be registered directly
  assign best_o     = best_d;
  assign second_o   = second_d;
  assign best_idx_o = idx_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      best_q   <= '0;
      second_q <= ONES;
      idx_q    <= '0;
    end else begin
      best_q   <= best_d;
      second_q <= second_d;
      idx_q    <= idx_d;
    end
endmodule

// File: rtl/disparity_selector.sv
// disparity_selector: winner-take-all over serial per-disparity window sums.
module disparity_selector
  import disparity_selector_pkg::*;
#(
  parameter int num_bits_in = NUM_BITS_IN,
  parameter int num_disp    = 16,
  parameter int disp_bits   = DISP_BITS,
  parameter int margin      = 8
) (
  input logic clk,
  input logic rst,
  disparity_selector_if.slave bus
);
  localparam logic [disp_bits-1:0]   LAST  = disp_bits'(num_disp - 1);
  localparam logic [num_bits_in:0]   MARGN = (num_bits_in + 1)'(margin);
  state_t                 state_q, state_d;
  logic [disp_bits-1:0]   cnt_q, cnt_d;
  logic [disp_bits-1:0]   disp_q, best_idx;
  logic [num_bits_in-1:0] min_q, best, second, diff;
  logic                   conf_q, dv_q, err_q;
  logic                   start, next_beat, in_sweep, upd, done, err_d;
  assign in_sweep  = state_q == SWEEP;
  assign start     = bus.sum_valid && bus.sum_first;
  assign next_beat = bus.sum_valid && !bus.sum_first;
  assign upd       = next_beat && in_sweep;
  assign err_d     = (start && in_sweep) || (next_beat && !in_sweep);
  assign done      = start ? (num_disp == 1) : (upd && cnt_q == LAST);
  always_comb begin
    state_d = done ? IDLE : start ? SWEEP : state_q;
    cnt_d   = start ? disp_bits'(1) : upd ? cnt_q + 1'b1 : cnt_q;
  end
  min_pair_tracker #(
    .num_bits_in(num_bits_in),
    .disp_bits  (disp_bits)
  ) u_tracker (
    .clk       (clk),
    .rst       (rst),
    .load_i    (start),
    .upd_i     (upd),
    .sum_i     (bus.sum_in),
    .idx_i     (cnt_q),
    .best_o    (best),
    .second_o  (second),
    .best_idx_o(best_idx)
  );
  assign diff = second - best;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      disp_q  <= '0;
      min_q   <= '0;
      conf_q  <= 1'b0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dv_q    <= done;
      err_q   <= err_d;
      if (done) begin
        disp_q <= best_idx;
        min_q  <= best;
        conf_q <= {1'b0, diff} >= MARGN;
      end
    end
  assign bus.disparity  = disp_q;
  assign bus.min_sum    = min_q;
  assign bus.confident  = conf_q;
  assign bus.disp_valid = dv_q;
  assign bus.sweep_err  = err_q;
endmodule

// File: tb/tb_disparity_selector.sv
// tb_disparity_selector: directed sweeps against a sort-based reference model.
module tb_disparity_selector;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  disparity_selector_if #(.num_bits_in(14), .disp_bits(4)) b4 ();
  disparity_selector_if #(.num_bits_in(14), .disp_bits(4)) b1 ();
  disparity_selector #(.num_bits_in(14), .num_disp(4), .disp_bits(4), .margin(8)) u4 (
    .clk(clk), .rst(rst), .bus(b4)
  );
  disparity_selector #(.num_bits_in(14), .num_disp(1), .disp_bits(4), .margin(8)) u1 (
    .clk(clk), .rst(rst), .bus(b1)
  );
  int tests = 0;
  int fails = 0;
  task automatic chk(input string n, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  // reference: collect a pixel's sums, sort them, winner is the first index holding the minimum
  int q[$];
  int s[$];
  bit in_sw = 0;
  int e_disp = 0, e_min = 0, e_conf = 0, e_dv = 0, e_err = 0;
  int bst, sec;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      in_sw = 0;
      e_disp = 0; e_min = 0; e_conf = 0; e_dv = 0; e_err = 0;
    end else begin
      e_dv = 0;
      e_err = 0;
      if (b4.sum_valid) begin
        if (b4.sum_first) begin
          e_err = int'(in_sw);
          q.delete();
          q.push_back(int'(b4.sum_in));
          in_sw = 1;
        end else if (!in_sw) e_err = 1;
        else q.push_back(int'(b4.sum_in));
        if (in_sw && q.size() == 4) begin
          s = q;
          s.sort();
          bst = s[0];
          sec = (s.size() > 1) ? s[1] : 16383;
          for (int i = q.size() - 1; i >= 0; i--) if (q[i] == bst) e_disp = i;
          e_min = bst;
          e_conf = ((sec - bst) >= 8) ? 1 : 0;
          e_dv = 1;
          in_sw = 0;
        end
      end
    end
  end
  always @(negedge clk)
    if (!rst) begin
      chk("disp_valid", int'(b4.disp_valid), e_dv);
      chk("sweep_err", int'(b4.sweep_err), e_err);
      chk("disparity", int'(b4.disparity), e_disp);
      chk("min_sum", int'(b4.min_sum), e_min);
      chk("confident", int'(b4.confident), e_conf);
    end
  task automatic send(input int v, input bit f);
    @(negedge clk);
    b4.sum_valid = 1'b1;
    b4.sum_first = f;
    b4.sum_in = 14'(v);
  endtask
  task automatic gap();
    @(negedge clk);
    b4.sum_valid = 1'b0;
    b4.sum_first = 1'b0;
  endtask
  task automatic pin(input string n, input int d, input int m, input int c);
    chk({n, "_dv"}, int'(b4.disp_valid), 1);
    chk({n, "_disp"}, int'(b4.disparity), d);
    chk({n, "_min"}, int'(b4.min_sum), m);
    chk({n, "_conf"}, int'(b4.confident), c);
  endtask
  task automatic send1(input int v);
    @(negedge clk);
    b1.sum_valid = 1'b1;
    b1.sum_first = 1'b1;
    b1.sum_in = 14'(v);
    @(negedge clk);
    b1.sum_valid = 1'b0;
    b1.sum_first = 1'b0;
  endtask
  task automatic pin1(input string n, input int m, input int c);
    chk({n, "_dv"}, int'(b1.disp_valid), 1);
    chk({n, "_disp"}, int'(b1.disparity), 0);
    chk({n, "_min"}, int'(b1.min_sum), m);
    chk({n, "_conf"}, int'(b1.confident), c);
  endtask
  task automatic all_zero(input string n);
    chk({n, "_dv"}, int'(b4.disp_valid), 0);
    chk({n, "_err"}, int'(b4.sweep_err), 0);
    chk({n, "_disp"}, int'(b4.disparity), 0);
    chk({n, "_min"}, int'(b4.min_sum), 0);
    chk({n, "_conf"}, int'(b4.confident), 0);
  endtask
  initial begin
    b4.sum_valid = 1'b0; b4.sum_first = 1'b0; b4.sum_in = '0;
    b1.sum_valid = 1'b0; b1.sum_first = 1'b0; b1.sum_in = '0;
    repeat (2) @(negedge clk);
    all_zero("reset");
    rst = 1'b0;
    send(50, 1); send(30, 0); send(45, 0); send(60, 0); gap();
    pin("sweep1", 1, 30, 1);
    send(40, 1); gap(); send(35, 0); gap(); gap(); send(35, 0); gap(); send(38, 0); gap();
    pin("sweep2", 1, 35, 0);
    send(50, 1); send(30, 0); send(45, 0); send(60, 0);
    send(40, 1);
    pin("b2b_a", 1, 30, 1);
    send(35, 0); send(35, 0); send(38, 0); gap();
    pin("b2b_b", 1, 35, 0);
    send(30, 1); send(38, 0); send(50, 0); send(60, 0); gap();
    pin("margin_eq", 0, 30, 1);
    send(50, 1); send(30, 0); send(20, 1); send(25, 0);
    chk("restart_err", int'(b4.sweep_err), 1);
    chk("restart_nodv", int'(b4.disp_valid), 0);
    send(27, 0); send(40, 0); gap();
    pin("restart", 0, 20, 0);
    send(7, 0); gap();
    chk("stray_err", int'(b4.sweep_err), 1);
    gap();
    chk("stray_once", int'(b4.sweep_err), 0);
    send(100, 1); send(20, 0); send(90, 0); send(60, 0); gap();
    pin("post_stray", 1, 20, 1);
    send(50, 1); send(30, 0); gap();
    #2 rst = 1'b1;
    #1 all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    send(45, 0); gap();
    chk("post_rst_stray", int'(b4.sweep_err), 1);
    send(50, 1); send(30, 0); send(45, 0); send(60, 0); gap();
    pin("post_rst", 1, 30, 1);
    send1(5);
    pin1("nd1_a", 5, 1);
    send1(16380);
    pin1("nd1_b", 16380, 0);
    send1(16375);
    pin1("nd1_c", 16375, 1);
    repeat (3) gap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/disparity_selector.md
Name: disparity_selector

Overview:
- Sink for the window-sum stream produced by the SAD accumulators: reads one window sum per candidate disparity for each pixel and picks the winning disparity (winner-take-all).
- Sums arrive serially, disparity 0 first, one per valid beat. Gaps between beats are allowed.
- Output is one registered result per pixel: best disparity, its sum, and a confidence flag from the best/second-best margin. The result feeds the depth-map writer.

Parameters:
- num_bits_in, 14, width of incoming window sum
- num_disp, 16, candidate disparities per pixel (legal range 1 to 256)
- disp_bits, 4, width of disparity index; must satisfy 2^disp_bits >= num_disp
- margin, 8, minimum (second_best - best) for the result to be marked confident

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- sum_in  in  num_bits_in  window sum for the current candidate disparity
- sum_valid  in  1  sum_in valid this cycle
- sum_first  in  1  qualifies sum_valid; marks disparity 0 of a new pixel
- disparity  out  disp_bits  winning disparity index
- min_sum  out  num_bits_in  window sum of the winner
- confident  out  1  (second_best - best) >= margin
- disp_valid  out  1  one-cycle pulse; disparity, min_sum and confident are valid
- sweep_err  out  1  one-cycle pulse on a protocol violation

Behaviour:
- Reset is asynchronous and active-high. While reset is high: all outputs 0, state IDLE, counter 0, best = 0, second = all-ones.
- States:
  - IDLE: waits for sum_valid && sum_first.
  - SWEEP: accepting sums for the current pixel.
- Start of sweep (accepted first beat):
  - best = sum_in, best_idx = 0, second = all-ones, cnt = 1.
  - If num_disp == 1, the sweep ends on this beat.
- Each subsequent beat with sum_valid && !sum_first in SWEEP, sum at index cnt:
  - if sum_in < best: second = best, best = sum_in, best_idx = cnt
  - else if sum_in < second: second = sum_in
  - cnt increments.
- Ties use strict compare, so the lower disparity wins. A sum equal to best updates second only.
- End of sweep: the beat with index num_disp-1 is accepted.
  - Next state is IDLE.
  - Results are registered and disp_valid is high on the following cycle: 1-cycle latency after the last sum.
  - confident is computed as a num_bits_in unsigned subtraction (second - best); no overflow is possible because second >= best.
  - For num_disp == 1, second remains all-ones and confident = 1 unless best is within margin of all-ones.
- Back-to-back pixels: a sum_first beat on the cycle disp_valid is high is legal and starts a new sweep. Output registers hold their values until the next disp_valid.
- sum_valid low: no state change. There is no timeout.
- Violations (sweep_err pulses 1 cycle after the offending beat):
  - sum_valid && sum_first while in SWEEP: the current sweep is discarded, no disp_valid is issued, and the new beat starts a fresh sweep.
  - sum_valid && !sum_first while in IDLE: the beat is ignored.
- Reset during SWEEP: the partial result is dropped and no disp_valid is issued.
- No backpressure: the consumer must accept disp_valid unconditionally.

Decomposition:
- Shared package holds:
  - default widths (num_bits_in = 14, disp_bits = 4)
  - the state encoding (IDLE = 0, SWEEP = 1)
  - the all-ones sentinel constant for second
- One sub-module, min_pair_tracker:
  - Sequential; holds best, best_idx and second.
  - Controls: load/start and update enable.
  - Parameterised by num_bits_in and disp_bits.
  - Top level keeps the FSM, the counter, error detection and the output registers.

Test Plan:
- Sweep 1: num_disp = 4, margin = 8, sums 50, 30, 45, 60 with no gaps -> one cycle after the 60 beat: disp_valid = 1, disparity = 1, min_sum = 30, confident = 1 (45 - 30 = 15).
- Sweep 2 (same configuration): sums 40, 35, 35, 38 with gaps inserted between beats -> disparity = 1 (tie resolves to lower index), min_sum = 35, confident = 0 (35 - 35 = 0).
- Back-to-back sweeps: Sweep 1 followed immediately by Sweep 2, with the next sum_first on the disp_valid cycle -> two disp_valid pulses exactly 4 beats apart, results 1/30/1 then 1/35/0.
- Restart mid-sweep: sum_first asserted on beat 3 of a 4-sum sweep -> sweep_err pulses once; no disp_valid for the aborted pixel; the restarted sweep completes normally with correct results.
- Stray beat: sum_valid without sum_first in IDLE -> sweep_err pulse; no state change; the next proper sweep is unaffected.
- Reset mid-sweep: reset asserted asynchronously after 2 beats -> all outputs 0 immediately. With num_disp = 1, sum 5 -> disparity = 0, min_sum = 5, confident = 1.
